// File: rtl/pipelined_add_sub_pkg.sv
// rtl/pipelined_add_sub_pkg.sv - shared defaults and chunk sizing for the pipelined adder/subtractor
package pipelined_add_sub_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_STAGES = 4;

  // Guarded so an illegal STAGES still elaborates far enough to hit the top-level check.
  function automatic int chunk_of(input int width, input int stages);
    return (stages < 1) ? width : width / stages;
  endfunction

endpackage

// File: rtl/add_chunk.sv
// rtl/add_chunk.sv - combinational ripple-carry segment, also reports the carry into its MSB
module add_chunk
  import pipelined_add_sub_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  always_comb begin
    logic c;
    s     = '0;
    c     = cin;
    c_msb = cin;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) c_msb = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/pipelined_add_sub.sv
// rtl/pipelined_add_sub.sv - pipelined two's-complement adder/subtractor, one carry-chain chunk per stage
module pipelined_add_sub
  import pipelined_add_sub_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = chunk_of(WIDTH, STAGES);

  if ((STAGES < 1) || (WIDTH % ((STAGES < 1) ? 1 : STAGES) != 0)) begin : g_param_check
    $error("pipelined_add_sub: WIDTH must be a multiple of STAGES and STAGES >= 1");
  end

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign b_eff    = sub ? ~b : b;
  assign c0       = sub | cin;

  // Stage k consumes operand chunk k; untouched upper operand bits ride along (skew)
  // and finished lower result chunks accumulate in r_q (de-skew) until the last stage.
  for (genvar k = 0; k < STAGES; k++) begin : stage
    localparam int  REM  = WIDTH - k * CHUNK;
    localparam int  DONE = (k + 1) * CHUNK;
    localparam bit  LAST = (k == STAGES - 1);

    logic [REM-1:0]   a_in, b_in;
    logic             c_in, v_in, ld;
    logic [CHUNK-1:0] s;
    logic             co, cm;
    logic             v_q, c_q;
    logic [DONE-1:0]  r_q;

    // The output stage only loads on a real operation so invalid slots never disturb sum/cout/ovf.
    assign ld = en && (!LAST || v_in);

    add_chunk #(.CHUNK(CHUNK)) u_add (
      .a     (a_in[CHUNK-1:0]),
      .b     (b_in[CHUNK-1:0]),
      .cin   (c_in),
      .s     (s),
      .cout  (co),
      .c_msb (cm)
    );

    if (k == 0) begin : src
      assign a_in = a;
      assign b_in = b_eff;
      assign c_in = c0;
      assign v_in = in_valid;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     r_q <= '0;
        else if (ld) r_q <= s;
      end
    end else begin : src
      assign a_in = stage[k-1].fwd.a_q;
      assign b_in = stage[k-1].fwd.b_q;
      assign c_in = stage[k-1].c_q;
      assign v_in = stage[k-1].v_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     r_q <= '0;
        else if (ld) r_q <= {s, stage[k-1].r_q};
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)     v_q <= 1'b0;
      else if (en) v_q <= v_in;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)     c_q <= 1'b0;
      else if (ld) c_q <= co;
    end

    if (!LAST) begin : fwd
      logic [REM-CHUNK-1:0] a_q, b_q;
      logic                 unused_cm;
      assign unused_cm = cm;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_in[REM-1:CHUNK];
          b_q <= b_in[REM-1:CHUNK];
        end
      end
    end else begin : last
      logic o_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     o_q <= 1'b0;
        else if (ld) o_q <= cm ^ co;
      end
    end
  end

  assign out_valid = stage[STAGES-1].v_q;
  assign sum       = stage[STAGES-1].r_q;
  assign cout      = stage[STAGES-1].c_q;
  assign ovf       = stage[STAGES-1].last.o_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb/tb_pipelined_add_sub.sv - randomized self-checking bench for pipelined_add_sub (16/4, 8/1, 32/8)
module tb_pipelined_add_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Arithmetic reference: {ovf, cout, sum} from plain integer maths on w-bit operands.
  function automatic logic [65:0] ref_op(input int w, input longint unsigned x, input longint unsigned y,
                                         input bit s, input bit c);
    longint unsigned m, u;
    longint          sx, sy, sr, half;
    bit              co;
    m    = 64'd1 << w;
    half = longint'(m >> 1);
    sx   = (x >= (m >> 1)) ? longint'(x) - longint'(m) : longint'(x);
    sy   = (y >= (m >> 1)) ? longint'(y) - longint'(m) : longint'(y);
    if (s) begin
      u  = (x + m - y) % m;
      co = (x >= y);
      sr = sx - sy;
    end else begin
      u  = (x + y + c) % m;
      co = ((x + y + c) >= m);
      sr = sx + sy + c;
    end
    return {((sr >= half) || (sr < -half)), co, 64'(u)};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int G = g;
    localparam int W = (g == 0) ? 16 : (g == 1) ? 8 : 32;
    localparam int S = (g == 0) ? 4 : (g == 1) ? 1 : 8;

    logic         rst, in_valid, in_ready, sub, cin, out_valid, out_ready, cout, ovf;
    logic [W-1:0] a, b, sum;
    logic [65:0]  exp_q[$];
    int           acc_q[$];
    int           rdy_mode = 0, t0 = 0, n_out = 0;
    bit           lat_on = 1'b0, fin = 1'b0, held = 1'b0;
    logic [W-1:0] h_sum;
    logic         h_cout, h_ovf;
    logic [65:0]  e;
    int           t;

    pipelined_add_sub #(.WIDTH(W), .STAGES(S)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
    );

    function automatic string nm(input string s);
      return $sformatf("c%0d %s", G, s);
    endfunction

    always @(posedge clk) begin
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = !(((cyc - t0) >= 6) && ((cyc - t0) <= 9));
      endcase
    end

    always @(negedge clk) begin
      if (rst !== 1'b0) begin
        exp_q.delete();
        acc_q.delete();
        held = 1'b0;
      end else begin
        if (held) begin
          chk(nm("hold valid"), out_valid, 1);
          chk(nm("hold sum"), sum, h_sum);
          chk(nm("hold cout"), cout, h_cout);
          chk(nm("hold ovf"), ovf, h_ovf);
        end
        if (out_valid && !out_ready) chk(nm("stall in_ready"), in_ready, 0);
        if (out_valid && out_ready) begin
          chk(nm("expected"), exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = acc_q.pop_front();
            n_out++;
            chk(nm("sum"), sum, e[W-1:0]);
            chk(nm("cout"), cout, e[64]);
            chk(nm("ovf"), ovf, e[65]);
            if (lat_on) chk(nm("latency"), cyc - t, S);
          end
        end
        held   = out_valid && !out_ready;
        h_sum  = sum;
        h_cout = cout;
        h_ovf  = ovf;
        if (in_valid && in_ready) begin
          exp_q.push_back(ref_op(W, a, b, sub, cin));
          acc_q.push_back(cyc);
        end
      end
    end

    task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic s, input logic c);
      bit ok = 1'b0;
      int n  = 0;
      a = aa; b = bb; sub = s; cin = c; in_valid = 1'b1;
      while (!ok && n < 200) begin
        @(negedge clk);
        ok = in_ready;
        @(posedge clk);
        #1;
        n++;
      end
      in_valid = 1'b0;
      if (!ok) chk(nm("accept timeout"), ok, 1);
    endtask

    function automatic logic [W-1:0] rnd();
      logic [W-1:0] v;
      case ($urandom_range(0, 7))
        0:       v = '0;
        1:       v = '1;
        2:       begin v = '0; v[W-1] = 1'b1; end
        default: v = W'($urandom);
      endcase
      return v;
    endfunction

    task automatic run_random(input int n);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 4) == 0) begin
          in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
        send(rnd(), rnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    endtask

    task automatic drain();
      rdy_mode = 0;
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
      chk(nm("drain"), exp_q.size(), 0);
      @(posedge clk);
      #1;
    endtask

    task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk(nm("rst out_valid"), out_valid, 0);
      chk(nm("rst sum"), sum, 0);
      chk(nm("rst cout"), cout, 0);
      chk(nm("rst ovf"), ovf, 0);
      chk(nm("rst in_ready"), in_ready, 1);
      rst = 1'b0;
    endtask

    if (g == 0) begin : d
      task automatic dir(input string tag, input logic [15:0] aa, input logic [15:0] bb,
                         input logic s, input logic c,
                         input logic [15:0] es, input logic ec, input logic eo);
        int lat = 1;
        bit got = 1'b0;
        send(aa, bb, s, c);
        while (!got && lat < 20) begin
          @(negedge clk);
          if (out_valid === 1'b1) got = 1'b1;
          else begin
            @(posedge clk);
            #1;
            lat++;
          end
        end
        chk({tag, " latency"}, lat, S);
        chk({tag, " sum"}, sum, es);
        chk({tag, " cout"}, cout, ec);
        chk({tag, " ovf"}, ovf, eo);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk({tag, " one-cycle"}, out_valid, 0);
        @(posedge clk);
        #1;
      endtask

      initial begin
        int n0, cnt;
        do_reset();
        lat_on = 1'b1;
        dir("add",    16'h1234, 16'h1111, 1'b0, 1'b1, 16'h2346, 1'b0, 1'b0);
        dir("carry",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        dir("ovf add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        dir("sub",    16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        dir("ovf sub", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        dir("sub b0", 16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1234, 1'b1, 1'b0);
        dir("a eq b", 16'hABCD, 16'hABCD, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

        lat_on   = 1'b0;
        n0       = n_out;
        t0       = cyc;
        rdy_mode = 2;
        for (int i = 0; i < 8; i++) send(rnd(), rnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drain();
        chk("c0 backpressure count", n_out - n0, 8);

        for (int i = 0; i < 3; i++) send(rnd(), rnd(), 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        chk("c0 midrst out_valid", out_valid, 0);
        chk("c0 midrst sum", sum, 0);
        chk("c0 midrst cout", cout, 0);
        chk("c0 midrst ovf", ovf, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cnt = 0;
        repeat (12) begin
          @(negedge clk);
          if (out_valid !== 1'b0) cnt++;
        end
        chk("c0 midrst no results", cnt, 0);
        @(posedge clk);
        #1;

        rdy_mode = 1;
        run_random(300);
        drain();
        fin = 1'b1;
      end
    end else begin : r
      initial begin
        do_reset();
        lat_on = 1'b1;
        run_random(30);
        drain();
        lat_on   = 1'b0;
        rdy_mode = 1;
        run_random(1000);
        drain();
        fin = 1'b1;
      end
    end
  end

  initial begin
    int i = 0;
    while (!(cfg[0].fin && cfg[1].fin && cfg[2].fin) && i < 60000) begin
      @(posedge clk);
      i++;
    end
    chk("all configs finished", cfg[0].fin && cfg[1].fin && cfg[2].fin, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
